// File: rtl/bcd_conv_arbiter.sv
// Shared 8-bit binary-to-BCD engine for two requesters with round-robin arbitration.
// Result and done pulse 8 edges after grant; requests are ignored while busy.
module bcd_conv_arbiter #(
  parameter int unsigned RR_RESET_LAST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [1:0] signed_mode,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] done,
  output logic       neg,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic LAST_RST = (RR_RESET_LAST != 0);

  state_t     state, state_nxt;
  logic       last;
  logic       win;
  logic [7:0] op;
  logic       op_neg;
  logic [7:0] op_mag;

  logic [7:0] mag;
  logic       sign_q;
  logic [2:0] cnt;
  logic       h_sr;
  logic [3:0] t_sr, o_sr;
  logic [3:0] t_adj, o_adj;
  logic [3:0] t_shf, o_shf;

  // A lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10)
      win = 1'b1;
    else if (req == 2'b11)
      win = ~last;
    op     = win ? data1 : data0;
    op_neg = signed_mode[win] & op[7];
    op_mag = op_neg ? (~op + 8'd1) : op;
  end

  // An 8-bit magnitude never pushes the hundreds digit past 2, so it needs no
  // add-3 correction and only its low bit has to be carried between steps.
  always_comb begin
    o_adj = (o_sr >= 4'd5) ? o_sr + 4'd3 : o_sr;
    t_adj = (t_sr >= 4'd5) ? t_sr + 4'd3 : t_sr;
    o_shf = {o_adj[2:0], mag[7]};
    t_shf = {t_adj[2:0], o_adj[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= 2'b00;
      last     <= LAST_RST;
      mag      <= 8'd0;
      sign_q   <= 1'b0;
      cnt      <= 3'd0;
      h_sr     <= 1'b0;
      t_sr     <= 4'd0;
      o_sr     <= 4'd0;
      neg      <= 1'b0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant  <= win ? 2'b10 : 2'b01;
            last   <= win;
            mag    <= op_mag;
            sign_q <= op_neg;
            cnt    <= 3'd7;
            h_sr   <= 1'b0;
            t_sr   <= 4'd0;
            o_sr   <= 4'd0;
          end
        end
        SHIFT: begin
          h_sr <= t_adj[3];
          t_sr <= t_shf;
          o_sr <= o_shf;
          mag  <= {mag[6:0], 1'b0};
          cnt  <= cnt - 3'd1;
          // Publish the final step straight into the output registers.
          if (cnt == 3'd0) begin
            neg      <= sign_q;
            hundreds <= {2'b00, h_sr, t_adj[3]};
            tens     <= t_shf;
            ones     <= o_shf;
          end
        end
        DONE: grant <= 2'b00;
        default: grant <= 2'b00;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) ? grant : 2'b00;

endmodule
